// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs R/Load/S/B fields into 32-bit words, queues them in a
// small FIFO and writes them to instruction memory at auto-incrementing word addresses.
module inst_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [6:0]                   op,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    input  logic [4:0]                   rd,
    input  logic [2:0]                   f3,
    input  logic [6:0]                   f7,
    input  logic [11:0]                  imm,
    input  logic                         addr_clr,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [31:0]                  wr_data,
    input  logic                         wr_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    function automatic logic op_supported(input logic [6:0] a_op);
        logic ok;
        case (a_op)
            OP_R, OP_LOAD, OP_S, OP_B: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Field placement mirrors the core decoder; the branch immediate is in decoder bit order.
    function automatic logic [31:0] encode(
        input logic [6:0]  a_op,
        input logic [4:0]  a_rs1,
        input logic [4:0]  a_rs2,
        input logic [4:0]  a_rd,
        input logic [2:0]  a_f3,
        input logic [6:0]  a_f7,
        input logic [11:0] a_imm
    );
        logic [31:0] w;
        case (a_op)
            OP_R:    w = {a_f7, a_rs2, a_rs1, a_f3, a_rd, a_op};
            OP_LOAD: w = {a_imm, a_rs1, a_f3, a_rd, a_op};
            OP_S:    w = {a_imm[11:5], a_rs2, a_rs1, a_f3, a_imm[4:0], a_op};
            OP_B:    w = {a_imm[11], a_imm[5:0], a_rs2, a_rs1, a_f3, a_imm[9:6], a_imm[10], a_op};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    state_e             state_q, state_d;
    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               err_q, err_d;

    logic               in_ready_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;

    // Handshake decode and next-state computation for FIFO, address counter and error flag.
    always_comb begin
        in_ready_s = rst_n && (count_q < DEPTH_C);
        accept_s   = in_valid && in_ready_s;
        push_s     = accept_s && op_supported(op);
        pop_s      = (state_q == ST_WRITE) && wr_ack;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q;
        state_d  = state_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = encode(op, rs1, rs2, rd, f3, f7, imm);
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end

        // addr_clr takes priority; the acked write already went out on the old address.
        if (addr_clr) begin
            addr_d = BASE_C;
        end else if (pop_s) begin
            addr_d = addr_q + ADDR_W'(1);
        end else begin
            addr_d = addr_q;
        end

        if (accept_s && !op_supported(op)) begin
            err_d = 1'b1;
        end else if (addr_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (push_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (pop_s && !push_s && (count_q == CNT_W'(1))) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
            addr_q   <= BASE_C;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers mark it empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Output drive: data is forced to zero whenever no write is requested.
    always_comb begin
        in_ready = in_ready_s;
        wr_en    = (state_q == ST_WRITE);
        wr_addr  = addr_q;
        count    = count_q;
        err      = err_q;
        if (state_q == ST_WRITE) begin
            wr_data = mem_q[rd_ptr_q];
        end else begin
            wr_data = 32'd0;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: drivers queue expected words, a negedge monitor
// compares every DUT output against a behavioural occupancy/address/error model.
module tb_inst_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  op = 7'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic [2:0]  f3 = 3'd0;
    logic [6:0]  f7 = 7'd0;
    logic [11:0] imm = 12'd0;
    logic        addr_clr = 1'b0;
    logic        wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack = 1'b0;
    logic [2:0]  count;
    logic        err;

    int checks = 0;
    int passes = 0;
    bit rand_on = 1'b0;

    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] obs_addr[$];
    int                m_cnt  = 0;
    int                m_addr = 0;
    bit                m_err  = 1'b0;

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .f3(f3), .f7(f7), .imm(imm),
        .addr_clr(addr_clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit ref_supported(input logic [6:0] o);
        return (o == 7'h33) || (o == 7'h03) || (o == 7'h23) || (o == 7'h63);
    endfunction

    // Reference encoder built from field positions with integer arithmetic.
    function automatic logic [31:0] ref_encode(input logic [6:0] o, input logic [4:0] a1,
            input logic [4:0] a2, input logic [4:0] ad, input logic [2:0] fn3,
            input logic [6:0] fn7, input logic [11:0] im);
        int unsigned uo, u1, u2, ud, u3, u7, ui, w;
        uo = o; u1 = a1; u2 = a2; ud = ad; u3 = fn3; u7 = fn7; ui = im;
        w = 0;
        if (uo == 32'h33)
            w = (u7 << 25) + (u2 << 20) + (u1 << 15) + (u3 << 12) + (ud << 7) + uo;
        else if (uo == 32'h03)
            w = (ui << 20) + (u1 << 15) + (u3 << 12) + (ud << 7) + uo;
        else if (uo == 32'h23)
            w = (((ui >> 5) % 128) << 25) + (u2 << 20) + (u1 << 15) + (u3 << 12)
              + ((ui % 32) << 7) + uo;
        else if (uo == 32'h63)
            w = (((ui >> 11) % 2) << 31) + ((ui % 64) << 25) + (u2 << 20) + (u1 << 15)
              + (u3 << 12) + (((ui >> 6) % 16) << 8) + (((ui >> 10) % 2) << 7) + uo;
        return w;
    endfunction

    // Monitor: compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        bit acc, pop;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (rst_n && m_cnt < DEPTH)});
        chk("count", {29'd0, count}, m_cnt);
        chk("wr_en", {31'd0, wr_en}, {31'd0, (m_cnt != 0)});
        chk("err", {31'd0, err}, {31'd0, m_err});
        if (m_cnt != 0) begin
            if (exp_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
            else chk("wr_data", wr_data, exp_q[0]);
            chk("wr_addr", {30'd0, wr_addr}, m_addr);
        end else begin
            chk("idle_data", wr_data, 32'd0);
        end
        if (wr_en && wr_ack) obs_addr.push_back(wr_addr);

        acc = in_valid && rst_n && (m_cnt < DEPTH);
        pop = (m_cnt != 0) && wr_ack;
        if (!rst_n) begin
            m_cnt = 0; m_addr = 0; m_err = 1'b0;
            exp_q.delete();
        end else begin
            if (pop) begin
                m_cnt--;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (acc && ref_supported(op)) m_cnt++;
            if (addr_clr) m_addr = 0;
            else if (pop) m_addr = (m_addr + 1) % (1 << ADDR_W);
            if (acc && !ref_supported(op)) m_err = 1'b1;
            else if (addr_clr) m_err = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_on) begin
            wr_ack   = ($urandom_range(0, 3) != 0);
            addr_clr = ($urandom_range(0, 15) == 0);
        end
    endtask

    // Present one field set, wait (bounded) for acceptance, record the expected word.
    task automatic send(input logic [6:0] o, input logic [4:0] a1, input logic [4:0] a2,
            input logic [4:0] ad, input logic [2:0] fn3, input logic [6:0] fn7,
            input logic [11:0] im, input logic [31:0] exp_w, input bit use_exp);
        int waited = 0;
        op = o; rs1 = a1; rs2 = a2; rd = ad; f3 = fn3; f7 = fn7; imm = im;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            step();
            @(negedge clk);
            waited++;
        end
        chk("accept", {31'd0, in_ready}, 32'd1);
        if (in_ready && ref_supported(o))
            exp_q.push_back(use_exp ? exp_w : ref_encode(o, a1, a2, ad, fn3, fn7, im));
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_rand_r();
        send(7'h33, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
             7'($urandom), 12'd0, 32'd0, 1'b0);
    endtask

    task automatic drain();
        int waited = 0;
        while (m_cnt != 0 && waited < 200) begin
            step();
            waited++;
        end
        chk("drain", m_cnt, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [6:0] o;
        repeat (3) step();
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        wr_ack = 1'b1;
        step();
        chk("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // R-type and one-cycle latency
        send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd0, 32'h002081B3, 1'b1);
        chk("lat_wr_en", {31'd0, wr_en}, 32'd1);
        chk("lat_wr_data", wr_data, 32'h002081B3);
        drain();

        // Load, store, branch back-to-back
        send(7'h03, 5'd2, 5'd0, 5'd5, 3'd2, 7'd0, 12'd8,    32'h00812283, 1'b1);
        send(7'h23, 5'd2, 5'd6, 5'd0, 3'd2, 7'd0, 12'd12,   32'h00612623, 1'b1);
        send(7'h63, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 12'h801,  32'h82208063, 1'b1);
        drain();

        // Backpressure: four fit, the fifth waits for acks
        addr_clr = 1'b1; step(); addr_clr = 1'b0;
        wr_ack = 1'b0;
        base = obs_addr.size();
        fork
            begin
                repeat (5) send_rand_r();
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                chk("bp_count", {29'd0, count}, 32'd4);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                wr_ack = 1'b1;
            end
        join
        drain();
        for (int i = 0; i < 4; i++)
            chk("bp_addr", {30'd0, obs_addr[base + i]}, i);

        // Address wrap with ADDR_W=2
        addr_clr = 1'b1; step(); addr_clr = 1'b0;
        base = obs_addr.size();
        repeat (5) send_rand_r();
        drain();
        for (int i = 0; i < 5; i++)
            chk("wrap_addr", {30'd0, obs_addr[base + i]}, i % 4);

        // Unsupported opcode, then addr_clr
        addr_clr = 1'b1; step(); addr_clr = 1'b0;
        send(7'h33, 5'd7, 5'd8, 5'd9, 3'd1, 7'd0, 12'd0, 32'd0, 1'b0);
        drain();
        send(7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 12'd5, 32'd0, 1'b0);
        chk("bad_err", {31'd0, err}, 32'd1);
        chk("bad_wr_en", {31'd0, wr_en}, 32'd0);
        chk("bad_count", {29'd0, count}, 32'd0);
        addr_clr = 1'b1; step(); addr_clr = 1'b0;
        chk("clr_err", {31'd0, err}, 32'd0);
        base = obs_addr.size();
        send_rand_r();
        drain();
        chk("clr_addr", {30'd0, obs_addr[base]}, 32'd0);

        // Reset mid-operation
        wr_ack = 1'b1;
        send_rand_r();
        drain();
        wr_ack = 1'b0;
        repeat (3) send_rand_r();
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        rst_n = 1'b0;
        step();
        chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_addr", {30'd0, wr_addr}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        wr_ack = 1'b1;
        step();

        // Randomised traffic with random acks and address clears
        rand_on = 1'b1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    o = 7'h33;
                2, 3:    o = 7'h03;
                4, 5:    o = 7'h23;
                6, 7:    o = 7'h63;
                8:       o = 7'h13;
                default: o = 7'($urandom);
            endcase
            send(o, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                 7'($urandom), 12'($urandom), 32'd0, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_on = 1'b0;
        wr_ack = 1'b1;
        addr_clr = 1'b0;
        drain();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
